// File: rtl/uart_mem_dumper_pkg.sv
// Shared definitions for the memory dump readback path.
package uart_mem_dumper_pkg;

    localparam int unsigned DEF_ISA_WIDTH = 32;
    localparam int unsigned DEF_ROM_DEPTH = 14;
    localparam int unsigned DEF_READ_LAT  = 1;
    localparam int unsigned BYTE_WIDTH    = 8;

    typedef enum logic [2:0] {
        DUMP_IDLE = 3'd0,
        DUMP_REQ  = 3'd1,
        DUMP_READ = 3'd2,
        DUMP_WAIT = 3'd3,
        DUMP_SEND = 3'd4,
        DUMP_DONE = 3'd5
    } dump_state_t;

    function automatic int unsigned bytes_per_word(input int unsigned isa_width);
        return isa_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/uart_mem_dumper_if.sv
// Memory read port and UART TX byte port of the dumper.
interface uart_mem_dumper_if
    import uart_mem_dumper_pkg::*;
#(
    parameter int unsigned ISA_WIDTH = DEF_ISA_WIDTH,
    parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH
);

    logic                  mem_req;
    logic                  mem_grant;
    logic [ROM_DEPTH:0]    mem_addr;
    logic                  mem_read_en;
    logic [ISA_WIDTH-1:0]  mem_rdata;
    logic                  tx_valid;
    logic [BYTE_WIDTH-1:0] tx_data;
    logic                  tx_ready;

    modport master (
        output mem_req, mem_addr, mem_read_en, tx_valid, tx_data,
        input  mem_grant, mem_rdata, tx_ready
    );

    modport slave (
        input  mem_req, mem_addr, mem_read_en, tx_valid, tx_data,
        output mem_grant, mem_rdata, tx_ready
    );

endinterface

// File: rtl/uart_mem_dumper_serializer.sv
// Splits one memory word into bytes, MSB first, behind a valid/ready stage.
module word_byte_serializer
    import uart_mem_dumper_pkg::*;
#(
    parameter int unsigned ISA_WIDTH = DEF_ISA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [ISA_WIDTH-1:0]  word,
    input  logic                  flush,
    input  logic                  tx_ready,
    output logic                  tx_valid,
    output logic [BYTE_WIDTH-1:0] tx_data,
    output logic                  last_byte,
    output logic                  fire
);

    localparam int unsigned BYTES_PER_WORD = bytes_per_word(ISA_WIDTH);
    localparam int unsigned IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;

    logic [ISA_WIDTH-1:0] shreg_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 valid_q;

    assign tx_valid  = valid_q;
    assign tx_data   = shreg_q[ISA_WIDTH-1 -: BYTE_WIDTH];
    assign last_byte = (idx_q == IDX_W'(BYTES_PER_WORD - 1));
    assign fire      = valid_q & tx_ready;

    // Hold the current byte until accepted, then shift the next one up.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (load) begin
            shreg_q <= word;
            idx_q   <= '0;
            valid_q <= 1'b1;
        end else if (fire) begin
            if (last_byte) begin
                valid_q <= 1'b0;
            end else begin
                shreg_q <= shreg_q << BYTE_WIDTH;
                idx_q   <= idx_q + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_mem_dumper.sv
// Reads a block of memory words and streams them as bytes to the UART TX.
module uart_mem_dumper
    import uart_mem_dumper_pkg::*;
#(
    parameter int unsigned ISA_WIDTH = DEF_ISA_WIDTH,
    parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH,
    parameter int unsigned READ_LAT  = DEF_READ_LAT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ROM_DEPTH:0] start_addr,
    input  logic [ROM_DEPTH:0] word_count,
    input  logic               abort,
    uart_mem_dumper_if.master  bus,
    output logic               busy,
    output logic               done,
    output logic [ROM_DEPTH:0] words_sent
);

    localparam int unsigned AW    = ROM_DEPTH + 1;
    localparam int unsigned LAT_W = 2;

    dump_state_t           state_q, state_d;
    logic [AW-1:0]         addr_q;
    logic [AW-1:0]         remain_q;
    logic [AW-1:0]         sent_q;
    logic [LAT_W-1:0]      lat_q;
    logic                  pend_q;

    logic                  req, rd_en;
    logic                  cmd_load, lat_inc, word_done, pend_set;
    logic                  ser_load, ser_flush, ser_fire, ser_last, ser_valid;
    logic [BYTE_WIDTH-1:0] ser_data;

    word_byte_serializer #(
        .ISA_WIDTH (ISA_WIDTH)
    ) u_ser (
        .clk       (clk),
        .rst       (rst),
        .load      (ser_load),
        .word      (bus.mem_rdata),
        .flush     (ser_flush),
        .tx_ready  (bus.tx_ready),
        .tx_valid  (ser_valid),
        .tx_data   (ser_data),
        .last_byte (ser_last),
        .fire      (ser_fire)
    );

    assign bus.mem_req     = req;
    assign bus.mem_read_en = rd_en;
    assign bus.mem_addr    = addr_q;
    assign bus.tx_valid    = ser_valid;
    assign bus.tx_data     = ser_data;
    assign busy            = (state_q != DUMP_IDLE);
    assign done            = (state_q == DUMP_DONE);
    assign words_sent      = sent_q;

    // Next-state and per-state strobes; abort wins over grant loss.
    always_comb begin
        state_d   = state_q;
        req       = 1'b0;
        rd_en     = 1'b0;
        cmd_load  = 1'b0;
        lat_inc   = 1'b0;
        ser_load  = 1'b0;
        ser_flush = 1'b0;
        word_done = 1'b0;
        pend_set  = 1'b0;
        case (state_q)
            DUMP_IDLE: begin
                if (start && !abort) begin
                    cmd_load = 1'b1;
                    state_d  = (word_count == '0) ? DUMP_DONE : DUMP_REQ;
                end
            end
            DUMP_REQ: begin
                req = 1'b1;
                if (abort)              state_d = DUMP_DONE;
                else if (bus.mem_grant) state_d = DUMP_READ;
            end
            DUMP_READ: begin
                req = 1'b1;
                if (abort) begin
                    state_d = DUMP_DONE;
                end else if (!bus.mem_grant) begin
                    state_d = DUMP_REQ;
                end else begin
                    rd_en   = 1'b1;
                    state_d = DUMP_WAIT;
                end
            end
            DUMP_WAIT: begin
                req = 1'b1;
                if (abort) begin
                    state_d = DUMP_DONE;
                end else if (!bus.mem_grant) begin
                    state_d = DUMP_REQ;
                end else if (lat_q == LAT_W'(READ_LAT - 1)) begin
                    ser_load = 1'b1;
                    state_d  = DUMP_SEND;
                end else begin
                    lat_inc = 1'b1;
                end
            end
            DUMP_SEND: begin
                // An abort seen mid-byte is remembered until that byte is taken.
                if (ser_fire) begin
                    word_done = ser_last;
                    if (abort || pend_q) begin
                        ser_flush = 1'b1;
                        state_d   = DUMP_DONE;
                    end else if (ser_last) begin
                        state_d = (remain_q == AW'(1)) ? DUMP_DONE : DUMP_REQ;
                    end
                end else if (abort) begin
                    pend_set = 1'b1;
                end
            end
            DUMP_DONE: begin
                state_d = DUMP_IDLE;
            end
            default: begin
                state_d = DUMP_IDLE;
            end
        endcase
    end

    // State, address/remaining/sent counters and read-latency counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= DUMP_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            sent_q   <= '0;
            lat_q    <= '0;
            pend_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lat_q   <= lat_inc ? lat_q + LAT_W'(1) : '0;
            pend_q  <= pend_set | (pend_q & (state_d == DUMP_SEND));
            if (cmd_load) begin
                addr_q   <= start_addr;
                remain_q <= word_count;
                sent_q   <= '0;
            end else if (word_done) begin
                sent_q   <= sent_q + AW'(1);
                remain_q <= remain_q - AW'(1);
                // Only the low bits advance; the memory-select bit is fixed per dump.
                if (state_d == DUMP_REQ)
                    addr_q <= {addr_q[ROM_DEPTH], addr_q[ROM_DEPTH-1:0] + ROM_DEPTH'(1)};
            end
        end
    end

endmodule

// File: tb/tb_uart_mem_dumper.sv
// Self-checking bench for uart_mem_dumper against a word/byte stream model.
module tb_uart_mem_dumper;

    localparam int unsigned AW = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] word_count = '0;
    logic          busy, done;
    logic [AW-1:0] words_sent;

    uart_mem_dumper_if #(.ISA_WIDTH(32), .ROM_DEPTH(14)) bus ();

    uart_mem_dumper #(
        .ISA_WIDTH (32),
        .ROM_DEPTH (14),
        .READ_LAT  (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .start_addr (start_addr),
        .word_count (word_count),
        .abort      (abort),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .words_sent (words_sent)
    );

    always #5 clk = ~clk;

    int unsigned checks = 0;
    int unsigned errors = 0;

    // Environment controls (written by the main sequence only).
    int unsigned grant_mode = 0;   // 0 always, 1 random, 2 scripted loss, 3 never
    bit          ready_rand = 1'b0;
    logic [31:0] seed = 32'h0;
    logic [31:0] ovr [logic [AW-1:0]];

    // Observations (written by the monitor only).
    logic [7:0]    rx_q [$];
    logic [AW-1:0] rd_log [$];
    int unsigned   done_cnt = 0, busy_cycles = 0, req_cycles = 0, txv_cycles = 0;
    bit            rd_pend = 1'b0;
    logic [AW-1:0] rd_pend_addr = '0;

    // Baselines taken by the main sequence before each dump.
    int unsigned b_rx = 0, b_rd = 0, b_done = 0, b_busy = 0, b_req = 0, b_txv = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_word(input logic [AW-1:0] a);
        if (ovr.exists(a)) return ovr[a];
        return (32'(a) * 32'h9E3779B1) ^ seed;
    endfunction

    // Word i of a dump: low 14 bits wrap, select bit kept.
    function automatic logic [AW-1:0] nth_addr(input logic [AW-1:0] base, input int unsigned i);
        int unsigned low;
        low = (32'(base[13:0]) + i) % 16384;
        return {base[14], 14'(low)};
    endfunction

    function automatic logic [7:0] exp_byte(input logic [AW-1:0] base, input int unsigned k);
        logic [31:0] w;
        w = model_word(nth_addr(base, k / 4));
        return 8'(w >> (8 * (3 - (k % 4))));
    endfunction

    // Memory responder and grant/ready drivers, updated just after each edge.
    initial begin
        int unsigned req_lo;
        bit dropped;
        req_lo = 0;
        dropped = 1'b0;
        bus.mem_grant = 1'b1;
        bus.tx_ready  = 1'b1;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mem_rdata = rd_pend ? model_word(rd_pend_addr) : $urandom;
            case (grant_mode)
                0: bus.mem_grant = 1'b1;
                1: bus.mem_grant = ($urandom_range(0, 3) != 0);
                2: begin
                    if (bus.mem_req && req_lo < 5) begin
                        bus.mem_grant = 1'b0;
                        req_lo++;
                    end else if (rd_pend && !dropped) begin
                        bus.mem_grant = 1'b0;
                        dropped = 1'b1;
                    end else begin
                        bus.mem_grant = 1'b1;
                    end
                end
                default: bus.mem_grant = 1'b0;
            endcase
            if (grant_mode != 2) begin
                req_lo = 0;
                dropped = 1'b0;
            end
            bus.tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: collects bytes/reads and checks handshake stability mid-cycle.
    initial begin
        bit stall_prev;
        bit done_prev;
        logic [7:0] stall_data;
        stall_prev = 1'b0;
        done_prev = 1'b0;
        stall_data = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (done_prev) check("post_done_idle", 32'(busy), 0);
                done_prev = done;
                if (done) done_cnt++;
                if (busy) busy_cycles++;
                if (bus.mem_req) req_cycles++;
                if (bus.tx_valid) begin
                    txv_cycles++;
                    check("port_released", 32'(bus.mem_req), 0);
                end
                if (stall_prev) begin
                    check("hold_valid", 32'(bus.tx_valid), 1);
                    check("hold_data", 32'(bus.tx_data), 32'(stall_data));
                end
                stall_prev = bus.tx_valid && !bus.tx_ready;
                stall_data = bus.tx_data;
                if (bus.tx_valid && bus.tx_ready) rx_q.push_back(bus.tx_data);
                if (bus.mem_read_en) rd_log.push_back(bus.mem_addr);
            end else begin
                stall_prev = 1'b0;
                done_prev = 1'b0;
            end
            rd_pend = bus.mem_read_en;
            rd_pend_addr = bus.mem_addr;
        end
    end

    task automatic mark();
        b_rx = rx_q.size(); b_rd = rd_log.size(); b_done = done_cnt;
        b_busy = busy_cycles; b_req = req_cycles; b_txv = txv_cycles;
    endtask

    task automatic pulse_start(input logic [AW-1:0] a, input logic [AW-1:0] n, input bit with_abort);
        @(posedge clk); #2;
        start = 1'b1; start_addr = a; word_count = n; abort = with_abort;
        @(posedge clk); #2;
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic pulse_abort();
        @(posedge clk); #2; abort = 1'b1;
        @(posedge clk); #2; abort = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int unsigned limit);
        int unsigned n;
        n = 0;
        while (done_cnt == b_done && n < limit) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 32'(done_cnt != b_done), 1);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_stream(input string tag, input logic [AW-1:0] base, input int unsigned nbytes);
        int unsigned got;
        got = rx_q.size() - b_rx;
        check({tag, "_nbytes"}, got, nbytes);
        for (int unsigned k = 0; k < got && k < nbytes; k++)
            check({tag, "_byte"}, 32'(rx_q[b_rx + k]), 32'(exp_byte(base, k)));
    endtask

    task automatic check_reads(input string tag, input logic [AW-1:0] base, input int unsigned n);
        check({tag, "_nreads"}, rd_log.size() - b_rd, n);
        for (int unsigned i = 0; i < n && b_rd + i < rd_log.size(); i++)
            check({tag, "_raddr"}, 32'(rd_log[b_rd + i]), 32'(nth_addr(base, i)));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 0);
        check({tag, "_done"}, 32'(done), 0);
        check({tag, "_tx_valid"}, 32'(bus.tx_valid), 0);
        check({tag, "_mem_req"}, 32'(bus.mem_req), 0);
        check({tag, "_read_en"}, 32'(bus.mem_read_en), 0);
        check({tag, "_mem_addr"}, 32'(bus.mem_addr), 0);
        check({tag, "_tx_data"}, 32'(bus.tx_data), 0);
        check({tag, "_words_sent"}, 32'(words_sent), 0);
    endtask

    task automatic run_dump(input string tag, input logic [AW-1:0] a, input int unsigned n);
        mark();
        pulse_start(a, AW'(n), 1'b0);
        wait_done(tag, 200 + n * 400);
        check_stream(tag, a, n * 4);
        check({tag, "_words_sent"}, 32'(words_sent), n);
        check({tag, "_done_cnt"}, done_cnt - b_done, 1);
    endtask

    initial begin
        logic [AW-1:0] a;
        int unsigned n;
        seed = $urandom;
        ovr[15'h0010] = 32'h11223344;
        ovr[15'h0011] = 32'hAABBCCDD;

        // Reset values while rst is held.
        repeat (3) @(posedge clk);
        #2;
        check_idle_outputs("reset");
        rst = 1'b0;

        // Two known words, MSB first, 7 cycles per word plus the DONE cycle.
        run_dump("basic", 15'h0010, 2);
        check_reads("basic", 15'h0010, 2);
        check("basic_busy_cycles", busy_cycles - b_busy, 15);
        check("basic_txv_cycles", txv_cycles - b_txv, 8);

        // Zero-length dump: straight to DONE, no port request, no bytes.
        a = AW'($urandom);
        mark();
        pulse_start(a, '0, 1'b0);
        wait_done("zero", 20);
        check("zero_done_cnt", done_cnt - b_done, 1);
        check("zero_busy_cycles", busy_cycles - b_busy, 1);
        check("zero_req_cycles", req_cycles - b_req, 0);
        check("zero_txv_cycles", txv_cycles - b_txv, 0);
        check("zero_words_sent", 32'(words_sent), 0);

        // Address wrap in instruction and data memory.
        run_dump("wrap_i", 15'h3FFF, 2);
        check_reads("wrap_i", 15'h3FFF, 2);
        run_dump("wrap_d", 15'h7FFF, 3);
        check_reads("wrap_d", 15'h7FFF, 3);

        // Grant withheld for 5 cycles, then lost during the first WAIT.
        grant_mode = 2;
        a = AW'($urandom);
        mark();
        pulse_start(a, AW'(3), 1'b0);
        wait_done("gloss", 400);
        check_stream("gloss", a, 12);
        check("gloss_nreads", rd_log.size() - b_rd, 4);
        if (rd_log.size() - b_rd == 4) begin
            check("gloss_raddr0", 32'(rd_log[b_rd]), 32'(a));
            check("gloss_raddr1", 32'(rd_log[b_rd + 1]), 32'(a));
            check("gloss_raddr2", 32'(rd_log[b_rd + 2]), 32'(nth_addr(a, 1)));
            check("gloss_raddr3", 32'(rd_log[b_rd + 3]), 32'(nth_addr(a, 2)));
        end
        check("gloss_words_sent", 32'(words_sent), 3);

        // 64 words with random grant and ready; a stray start while busy.
        grant_mode = 1;
        ready_rand = 1'b1;
        a = AW'($urandom);
        mark();
        pulse_start(a, AW'(64), 1'b0);
        repeat (10) @(posedge clk);
        pulse_start(AW'($urandom), AW'(5), 1'b0);
        wait_done("rand", 40000);
        check_stream("rand", a, 256);
        check("rand_words_sent", 32'(words_sent), 64);
        check("rand_done_cnt", done_cnt - b_done, 1);

        // Abort while waiting for a grant.
        grant_mode = 3;
        ready_rand = 1'b0;
        a = AW'($urandom);
        mark();
        pulse_start(a, AW'(2), 1'b0);
        repeat (3) @(posedge clk);
        pulse_abort();
        wait_done("ab_req", 20);
        check("ab_req_nbytes", rx_q.size() - b_rx, 0);
        check("ab_req_nreads", rd_log.size() - b_rd, 0);
        check("ab_req_words_sent", 32'(words_sent), 0);
        check("ab_req_done_cnt", done_cnt - b_done, 1);

        // Abort while byte 2 of word 3 is on offer.
        grant_mode = 1;
        ready_rand = 1'b1;
        a = AW'($urandom);
        mark();
        pulse_start(a, AW'(6), 1'b0);
        n = 0;
        while (rx_q.size() - b_rx < 14 && n < 2000) begin
            @(posedge clk); #2;
            n++;
        end
        check("ab_send_reach", rx_q.size() - b_rx, 14);
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        wait_done("ab_send", 200);
        check_stream("ab_send", a, 15);
        check("ab_send_words_sent", 32'(words_sent), 3);
        check("ab_send_done_cnt", done_cnt - b_done, 1);

        // start and abort together in IDLE: nothing happens.
        grant_mode = 0;
        ready_rand = 1'b0;
        mark();
        pulse_start(AW'($urandom), AW'(3), 1'b1);
        repeat (5) @(negedge clk);
        check("sa_done_cnt", done_cnt - b_done, 0);
        check("sa_busy_cycles", busy_cycles - b_busy, 0);
        check("sa_req_cycles", req_cycles - b_req, 0);

        // Reset in the middle of a dump.
        a = AW'($urandom);
        mark();
        pulse_start(a, AW'(4), 1'b0);
        n = 0;
        while (rx_q.size() - b_rx < 5 && n < 200) begin
            @(posedge clk); #2;
            n++;
        end
        check("rst_reach", 32'(rx_q.size() - b_rx >= 5), 1);
        rst = 1'b1;
        @(posedge clk); #2;
        check_idle_outputs("rst_mid");
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_mid_no_done", done_cnt - b_done, 0);
        check("rst_mid_idle", 32'(busy), 0);

        // Normal operation after the reset.
        run_dump("after_rst", 15'h4123, 1);
        check_reads("after_rst", 15'h4123, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
